data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 168 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-organised data memory behind a valid/ready request/response handshake.
// Handles RISC-V load/store sizes: b, h, w, bu, hu. Illegal requests skip the
// memory and produce an error response one cycle after acceptance.
module data_mem_responder #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  state_t state, state_nxt;

  logic [31:0] mem [DEPTH];

  logic              we_q;
  logic [ADDR_W+1:0] addr_q;
  logic [2:0]        size_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              accept;
  logic              req_illegal;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       ld_data;
  logic [31:0]       wr_bytes;
  logic [3:0]        be;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign accept    = req_valid & req_ready;

  // Legality of the request currently presented on the req_* inputs
  always_comb begin
    req_illegal = 1'b0;
    case (req_size)
      SZ_B, SZ_BU: req_illegal = 1'b0;
      SZ_H, SZ_HU: req_illegal = req_addr[0];
      SZ_W:        req_illegal = (req_addr[1:0] != 2'b00);
      default:     req_illegal = 1'b1;
    endcase
    if (req_we && (req_size == SZ_BU || req_size == SZ_HU)) req_illegal = 1'b1;
    if (req_addr[31:ADDR_W+2] != '0) req_illegal = 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = req_illegal ? RESP : ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read-side datapath: word select, lane select and extension
  always_comb begin
    word_idx = addr_q[ADDR_W+1:2];
    rd_word  = mem[word_idx];
    rd_byte  = rd_word[8*addr_q[1:0] +: 8];
    rd_half  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (size_q)
      SZ_B:    ld_data = {{24{rd_byte[7]}}, rd_byte};
      SZ_BU:   ld_data = {24'h0, rd_byte};
      SZ_H:    ld_data = {{16{rd_half[15]}}, rd_half};
      SZ_HU:   ld_data = {16'h0, rd_half};
      SZ_W:    ld_data = rd_word;
      default: ld_data = '0;
    endcase
  end

  // Write-side datapath: replicate store data across lanes, enable the targeted ones
  always_comb begin
    case (size_q)
      SZ_B: begin
        wr_bytes = {4{wdata_q[7:0]}};
        be       = 4'b0001 << addr_q[1:0];
      end
      SZ_H: begin
        wr_bytes = {2{wdata_q[15:0]}};
        be       = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      SZ_W: begin
        wr_bytes = wdata_q;
        be       = 4'b1111;
      end
      default: begin
        wr_bytes = wdata_q;
        be       = 4'b0000;
      end
    endcase
  end

  // Request capture and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr[ADDR_W+1:0];
        size_q  <= req_size;
        wdata_q <= req_wdata;
        if (req_illegal) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
      if (state == ACCESS) begin
        rdata_q <= we_q ? '0 : ld_data;
        err_q   <= 1'b0;
      end
      if (state == RESP && rsp_ready) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  // Store commit on the edge leaving ACCESS. Reset asynchronously forces IDLE,
  // so a reset held low at that edge already blocks the write without gating here.
  always_ff @(posedge clk) begin
    if (state == ACCESS && we_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wr_bytes[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: loads/stores of each size, error
// responses, response back-pressure and reset during ACCESS.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request, wait for the response (bounded), check latency and payload.
  // Inputs are driven #1 after a rising edge; outputs are sampled at the same point.
  task automatic send(input string tag, input logic we, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata,
                      input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_size  = size;
    req_wdata = wdata;
    check({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check({tag, ".busy"}, {31'h0, busy}, 32'h1);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".rdata"}, rsp_rdata, exp_rdata);
    check({tag, ".err"}, {31'h0, rsp_err}, {31'h0, exp_err});
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, ".idle"}, {30'h0, rsp_valid, req_ready}, 32'h1);
  endtask

  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata,
                      input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
    send(tag, we, addr, size, wdata, exp_lat, exp_rdata, exp_err);
    finish_rsp(tag);
  endtask

  logic [31:0] held_rdata;

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_size  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;

    #3;
    check("rst.outs", {27'h0, req_ready, rsp_valid, rsp_err, busy, 1'b0}, 32'h10);
    check("rst.rdata", rsp_rdata, 32'h0);
    @(posedge clk); @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst.idle", {30'h0, busy, req_ready}, 32'h1);

    // word store then load
    xact("sw10", 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 2, 32'h0, 1'b0);
    xact("lw10", 1'b0, 32'h10, 3'b010, 32'h0, 2, 32'hDEADBEEF, 1'b0);

    // byte store into a known word, then signed/unsigned/word readback
    xact("sw10b", 1'b1, 32'h10, 3'b010, 32'h11223344, 2, 32'h0, 1'b0);
    xact("sb13", 1'b1, 32'h13, 3'b000, 32'h000000A5, 2, 32'h0, 1'b0);
    xact("lb13", 1'b0, 32'h13, 3'b000, 32'h0, 2, 32'hFFFFFFA5, 1'b0);
    xact("lbu13", 1'b0, 32'h13, 3'b100, 32'h0, 2, 32'h000000A5, 1'b0);
    xact("lw10c", 1'b0, 32'h10, 3'b010, 32'h0, 2, 32'hA5223344, 1'b0);
    xact("lb11", 1'b0, 32'h11, 3'b000, 32'h0, 2, 32'h00000033, 1'b0);

    // halfword store in upper lanes, signed/unsigned loads
    xact("sh1a", 1'b1, 32'h1A, 3'b001, 32'hCAFEBEEF, 2, 32'h0, 1'b0);
    xact("lh1a", 1'b0, 32'h1A, 3'b001, 32'h0, 2, 32'hFFFFBEEF, 1'b0);
    xact("lhu1a", 1'b0, 32'h1A, 3'b101, 32'h0, 2, 32'h0000BEEF, 1'b0);

    // error responses: one cycle latency, no memory effect
    xact("lh11", 1'b0, 32'h11, 3'b001, 32'h0, 1, 32'h0, 1'b1);
    xact("lw10d", 1'b0, 32'h10, 3'b010, 32'h0, 2, 32'hA5223344, 1'b0);
    xact("sw0", 1'b1, 32'h0, 3'b010, 32'hCAFEF00D, 2, 32'h0, 1'b0);
    xact("sw400", 1'b1, 32'h400, 3'b010, 32'h00000055, 1, 32'h0, 1'b1);
    xact("lw0", 1'b0, 32'h0, 3'b010, 32'h0, 2, 32'hCAFEF00D, 1'b0);
    xact("sz011", 1'b0, 32'h10, 3'b011, 32'h0, 1, 32'h0, 1'b1);
    xact("sbu", 1'b1, 32'h10, 3'b100, 32'h77, 1, 32'h0, 1'b1);
    xact("lw12", 1'b0, 32'h12, 3'b010, 32'h0, 1, 32'h0, 1'b1);
    xact("lw10e", 1'b0, 32'h10, 3'b010, 32'h0, 2, 32'hA5223344, 1'b0);

    // response back-pressure: five stalled cycles with a competing request
    send("stall", 1'b0, 32'h10, 3'b010, 32'h0, 2, 32'hA5223344, 1'b0);
    held_rdata = rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h10;
      req_size  = 3'b010;
      req_wdata = 32'h0;
      @(posedge clk);
      #1;
      check("stall.hold", {rsp_valid, req_ready, rsp_err, busy, 28'h0},
            {4'b1001, 28'h0});
      check("stall.rdata", rsp_rdata, held_rdata);
    end
    req_valid = 1'b0;
    finish_rsp("stall");
    xact("lw10f", 1'b0, 32'h10, 3'b010, 32'h0, 2, 32'hA5223344, 1'b0);

    // reset during ACCESS suppresses the store
    xact("sw20", 1'b1, 32'h20, 3'b010, 32'h11111111, 2, 32'h0, 1'b0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_size  = 3'b010;
    req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rstacc.busy", {31'h0, busy}, 32'h1);
    reset = 1'b0;
    #1;
    check("rstacc.outs", {27'h0, req_ready, rsp_valid, rsp_err, busy, 1'b0}, 32'h10);
    check("rstacc.rdata", rsp_rdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    xact("lw20", 1'b0, 32'h20, 3'b010, 32'h0, 2, 32'h11111111, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
